// File: rtl/vscale_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vscale_rr_arbiter_if
//  Description : Bundle of the per-core HASTI buses, the shared dmem slave
//                bus and the arbiter status outputs. The arbiter connects
//                through the slave modport; the core/slave environment
//                connects through the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vscale_rr_arbiter_if #(
    parameter int NUM_CORES      = 2,
    parameter int CORE_IDX_WIDTH = 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_WIDTH      = 32
);
    // Per-core buses, core i occupies slice i
    logic [NUM_CORES*ADDR_WIDTH-1:0] core_haddr;
    logic [NUM_CORES-1:0]            core_hwrite;
    logic [NUM_CORES*3-1:0]          core_hsize;
    logic [NUM_CORES*3-1:0]          core_hburst;
    logic [NUM_CORES*4-1:0]          core_hprot;
    logic [NUM_CORES-1:0]            core_hmastlock;
    logic [NUM_CORES*2-1:0]          core_htrans;
    logic [NUM_CORES*BUS_WIDTH-1:0]  core_hwdata;
    logic [NUM_CORES*BUS_WIDTH-1:0]  core_hrdata;
    logic [NUM_CORES-1:0]            core_hready;
    logic [NUM_CORES-1:0]            core_hresp;

    // Shared dmem slave bus
    logic [CORE_IDX_WIDTH+ADDR_WIDTH-1:0] dmem_haddr;
    logic                                 dmem_hwrite;
    logic [2:0]                           dmem_hsize;
    logic [2:0]                           dmem_hburst;
    logic                                 dmem_hmastlock;
    logic [3:0]                           dmem_hprot;
    logic [1:0]                           dmem_htrans;
    logic [BUS_WIDTH-1:0]                 dmem_hwdata;
    logic [BUS_WIDTH-1:0]                 dmem_hrdata;
    logic                                 dmem_hready;
    logic                                 dmem_hresp;

    // Arbiter status
    logic [CORE_IDX_WIDTH-1:0] grant_idx;
    logic [CORE_IDX_WIDTH-1:0] data_idx;
    logic                      data_valid;

    // Arbiter side
    modport slave (
        input  core_haddr, core_hwrite, core_hsize, core_hburst, core_hprot,
               core_hmastlock, core_htrans, core_hwdata,
               dmem_hrdata, dmem_hready, dmem_hresp,
        output core_hrdata, core_hready, core_hresp,
               dmem_haddr, dmem_hwrite, dmem_hsize, dmem_hburst,
               dmem_hmastlock, dmem_hprot, dmem_htrans, dmem_hwdata,
               grant_idx, data_idx, data_valid
    );

    // Environment side (cores + dmem slave)
    modport master (
        output core_haddr, core_hwrite, core_hsize, core_hburst, core_hprot,
               core_hmastlock, core_htrans, core_hwdata,
               dmem_hrdata, dmem_hready, dmem_hresp,
        input  core_hrdata, core_hready, core_hresp,
               dmem_haddr, dmem_hwrite, dmem_hsize, dmem_hburst,
               dmem_hmastlock, dmem_hprot, dmem_htrans, dmem_hwdata,
               grant_idx, data_idx, data_valid
    );
endinterface
`default_nettype wire

// File: rtl/vscale_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vscale_rr_arbiter
//  Description : N-core HASTI data-memory arbiter with round-robin grant,
//                hmastlock support and separate address/data phase owners
//                so that slave wait states never misroute data.
//  Revision    : 1.0 - initial release
// ============================================================================
module vscale_rr_arbiter #(
    parameter int NUM_CORES      = 2,
    parameter int CORE_IDX_WIDTH = 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_WIDTH      = 32,
    parameter int TAG_CORE       = 1
) (
    input  wire                  clk,
    input  wire                  reset,
    vscale_rr_arbiter_if.slave   bus
);

    // Phase state: address-phase owner, data-phase owner, data-phase valid
    logic [CORE_IDX_WIDTH-1:0] r_grant;
    logic [CORE_IDX_WIDTH-1:0] r_data_owner;
    logic                      r_data_valid;

    // Unpacked views of the flattened per-core buses
    logic [ADDR_WIDTH-1:0] w_core_haddr  [NUM_CORES];
    logic [2:0]            w_core_hsize  [NUM_CORES];
    logic [2:0]            w_core_hburst [NUM_CORES];
    logic [3:0]            w_core_hprot  [NUM_CORES];
    logic [1:0]            w_core_htrans [NUM_CORES];
    logic [BUS_WIDTH-1:0]  w_core_hwdata [NUM_CORES];

    logic [NUM_CORES-1:0]      w_req;
    logic [NUM_CORES-1:0]      w_hready;
    logic [NUM_CORES-1:0]      w_hresp;
    logic [CORE_IDX_WIDTH-1:0] w_next_grant;
    logic                      w_found;
    logic                      w_hold_lock;
    int                        w_cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
            assign w_core_haddr[gi]  = bus.core_haddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_core_hsize[gi]  = bus.core_hsize[gi*3 +: 3];
            assign w_core_hburst[gi] = bus.core_hburst[gi*3 +: 3];
            assign w_core_hprot[gi]  = bus.core_hprot[gi*4 +: 4];
            assign w_core_htrans[gi] = bus.core_htrans[gi*2 +: 2];
            assign w_core_hwdata[gi] = bus.core_hwdata[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    // A core requests when its htrans is NONSEQ or SEQ (msb set)
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_req[i] = w_core_htrans[i][1];
        end
    end

    // Round-robin search starting after the current owner, owner itself last
    always_comb begin
        w_next_grant = r_grant;
        w_found      = 1'b0;
        w_cand       = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_cand = (int'(r_grant) + k) % NUM_CORES;
            if (!w_found && w_req[w_cand]) begin
                w_next_grant = w_cand[CORE_IDX_WIDTH-1:0];
                w_found      = 1'b1;
            end
        end
    end

    // A requesting owner that asserts hmastlock keeps the bus
    assign w_hold_lock = w_req[r_grant] & bus.core_hmastlock[r_grant];

    // Phase state advances only when the slave accepts (hready high)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_data_owner <= '0;
            r_data_valid <= 1'b0;
        end else if (bus.dmem_hready) begin
            r_data_owner <= r_grant;
            r_data_valid <= w_req[r_grant];
            if (!w_hold_lock) begin
                r_grant <= w_next_grant;
            end
        end
    end

    // Per-core ready/response: owners see the slave, requesting non-owners
    // stall, idle non-owners see a zero-wait OKAY
    always_comb begin
        w_hready = '0;
        w_hresp  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if ((r_grant == CORE_IDX_WIDTH'(i)) ||
                (r_data_valid && (r_data_owner == CORE_IDX_WIDTH'(i)))) begin
                w_hready[i] = bus.dmem_hready;
            end else if (w_req[i]) begin
                w_hready[i] = 1'b0;
            end else begin
                w_hready[i] = 1'b1;
            end
            if (r_data_valid && (r_data_owner == CORE_IDX_WIDTH'(i))) begin
                w_hresp[i] = bus.dmem_hresp;
            end
        end
    end

    // Address phase attributes follow the grant
    generate
        if (TAG_CORE != 0) begin : g_tag
            assign bus.dmem_haddr = {r_grant, w_core_haddr[r_grant]};
        end else begin : g_notag
            assign bus.dmem_haddr = {{CORE_IDX_WIDTH{1'b0}}, w_core_haddr[r_grant]};
        end
    endgenerate

    assign bus.dmem_hwrite    = bus.core_hwrite[r_grant];
    assign bus.dmem_hsize     = w_core_hsize[r_grant];
    assign bus.dmem_hburst    = w_core_hburst[r_grant];
    assign bus.dmem_hmastlock = bus.core_hmastlock[r_grant];
    assign bus.dmem_hprot     = w_core_hprot[r_grant];
    assign bus.dmem_htrans    = w_core_htrans[r_grant];

    // Write data follows the data-phase owner, even when the phase is empty
    assign bus.dmem_hwdata = w_core_hwdata[r_data_owner];

    // Read data is broadcast; only the owner's hready makes it meaningful
    assign bus.core_hrdata = {NUM_CORES{bus.dmem_hrdata}};
    assign bus.core_hready = w_hready;
    assign bus.core_hresp  = w_hresp;

    assign bus.grant_idx  = r_grant;
    assign bus.data_idx   = r_data_owner;
    assign bus.data_valid = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_vscale_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vscale_rr_arbiter
//  Description : Table-driven bench for vscale_rr_arbiter, 4 cores. A second
//                instance with TAG_CORE=0 shares the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vscale_rr_arbiter;

    localparam int C_N  = 4;
    localparam int C_IW = 2;
    localparam int C_AW = 32;
    localparam int C_BW = 32;

    logic clk;
    logic reset;

    logic [C_N*C_AW-1:0] tb_haddr;
    logic [C_N-1:0]      tb_hwrite;
    logic [C_N*3-1:0]    tb_hsize;
    logic [C_N*3-1:0]    tb_hburst;
    logic [C_N*4-1:0]    tb_hprot;
    logic [C_N-1:0]      tb_lock;
    logic [C_N*2-1:0]    tb_htrans;
    logic [C_N*C_BW-1:0] tb_hwdata;
    logic [C_BW-1:0]     tb_hrdata;
    logic                tb_hready;
    logic                tb_hresp;

    logic [C_AW-1:0] addr_tbl [C_N];
    logic [C_BW-1:0] wdat_tbl [C_N];

    vscale_rr_arbiter_if #(.NUM_CORES(C_N), .CORE_IDX_WIDTH(C_IW),
        .ADDR_WIDTH(C_AW), .BUS_WIDTH(C_BW)) bus ();
    vscale_rr_arbiter_if #(.NUM_CORES(C_N), .CORE_IDX_WIDTH(C_IW),
        .ADDR_WIDTH(C_AW), .BUS_WIDTH(C_BW)) bus0 ();

    assign bus.core_haddr     = tb_haddr;
    assign bus.core_hwrite    = tb_hwrite;
    assign bus.core_hsize     = tb_hsize;
    assign bus.core_hburst    = tb_hburst;
    assign bus.core_hprot     = tb_hprot;
    assign bus.core_hmastlock = tb_lock;
    assign bus.core_htrans    = tb_htrans;
    assign bus.core_hwdata    = tb_hwdata;
    assign bus.dmem_hrdata    = tb_hrdata;
    assign bus.dmem_hready    = tb_hready;
    assign bus.dmem_hresp     = tb_hresp;

    assign bus0.core_haddr     = tb_haddr;
    assign bus0.core_hwrite    = tb_hwrite;
    assign bus0.core_hsize     = tb_hsize;
    assign bus0.core_hburst    = tb_hburst;
    assign bus0.core_hprot     = tb_hprot;
    assign bus0.core_hmastlock = tb_lock;
    assign bus0.core_htrans    = tb_htrans;
    assign bus0.core_hwdata    = tb_hwdata;
    assign bus0.dmem_hrdata    = tb_hrdata;
    assign bus0.dmem_hready    = tb_hready;
    assign bus0.dmem_hresp     = tb_hresp;

    vscale_rr_arbiter #(.NUM_CORES(C_N), .CORE_IDX_WIDTH(C_IW),
        .ADDR_WIDTH(C_AW), .BUS_WIDTH(C_BW), .TAG_CORE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    vscale_rr_arbiter #(.NUM_CORES(C_N), .CORE_IDX_WIDTH(C_IW),
        .ADDR_WIDTH(C_AW), .BUS_WIDTH(C_BW), .TAG_CORE(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] htrans;
        logic [3:0] lock;
        logic       rdy;
        logic       resp;
        logic [1:0] g;
        logic [1:0] d;
        logic       v;
        logic [3:0] hrdy;
        logic [3:0] hresp;
    } vec_t;

    localparam int C_NV = 30;
    vec_t vecs [C_NV];

    int total;
    int bad;
    int cur;

    // Compare one observed value against the bench's expectation
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, cur, act, exp);
        end
    endtask

    initial begin
        logic [C_N*C_BW-1:0] exp_rd;
        logic [7:0]          ht;
        int                  cyc;
        total = 0;
        bad   = 0;
        cur   = -1;

        // Core addresses/data; core 2 writes 0xDEADBEEF to 0x100
        addr_tbl[0] = 32'h0000_0120; wdat_tbl[0] = 32'hA000_0000;
        addr_tbl[1] = 32'h0000_0130; wdat_tbl[1] = 32'hA000_0001;
        addr_tbl[2] = 32'h0000_0100; wdat_tbl[2] = 32'hDEAD_BEEF;
        addr_tbl[3] = 32'h0000_0110; wdat_tbl[3] = 32'hA000_0003;
        for (int i = 0; i < C_N; i++) begin
            tb_haddr[i*C_AW +: C_AW]  = addr_tbl[i];
            tb_hwdata[i*C_BW +: C_BW] = wdat_tbl[i];
        end
        tb_hwrite = 4'b0100;
        tb_hsize  = '0;
        tb_hburst = '0;
        tb_hprot  = '0;
        tb_lock   = '0;
        tb_htrans = '0;
        tb_hrdata = '0;
        tb_hready = 1'b1;
        tb_hresp  = 1'b0;

        //            htrans  lock  rdy   resp  g     d     v     hrdy   hresp
        // single core 2
        vecs[0]  = '{8'h20, 4'h0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'hB, 4'h0};
        vecs[1]  = '{8'h20, 4'h0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 4'hF, 4'h0};
        vecs[2]  = '{8'h00, 4'h0, 1'b1, 1'b0, 2'd2, 2'd2, 1'b1, 4'hF, 4'h0};
        vecs[3]  = '{8'h00, 4'h0, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 4'hF, 4'h0};
        // contention cores 0/1
        vecs[4]  = '{8'h0A, 4'h0, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 4'hC, 4'h0};
        vecs[5]  = '{8'h0A, 4'h0, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 4'hD, 4'h0};
        vecs[6]  = '{8'h0A, 4'h0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 4'hF, 4'h0};
        vecs[7]  = '{8'h0A, 4'h0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 4'hF, 4'h0};
        vecs[8]  = '{8'h0A, 4'h0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 4'hF, 4'h0};
        // stall during core 1's data phase
        vecs[9]  = '{8'h0A, 4'h0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 4'hC, 4'h0};
        vecs[10] = '{8'h0A, 4'h0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 4'hC, 4'h0};
        vecs[11] = '{8'h0A, 4'h0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 4'hC, 4'h0};
        vecs[12] = '{8'h0A, 4'h0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 4'hF, 4'h0};
        vecs[13] = '{8'h00, 4'h0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 4'hF, 4'h0};
        vecs[14] = '{8'h00, 4'h0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 4'hF, 4'h0};
        // core 0 locked for 4 transfers while core 1 requests
        vecs[15] = '{8'h0A, 4'h1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 4'hE, 4'h0};
        vecs[16] = '{8'h0A, 4'h1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 4'hF, 4'h0};
        vecs[17] = '{8'h0A, 4'h1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 4'hD, 4'h0};
        vecs[18] = '{8'h0A, 4'h1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 4'hD, 4'h0};
        vecs[19] = '{8'h0A, 4'h1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 4'hD, 4'h0};
        vecs[20] = '{8'h0A, 4'h0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 4'hD, 4'h0};
        vecs[21] = '{8'h08, 4'h0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 4'hF, 4'h0};
        vecs[22] = '{8'h00, 4'h0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 4'hF, 4'h0};
        // error response in core 3's data phase
        vecs[23] = '{8'h80, 4'h0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 4'h7, 4'h0};
        vecs[24] = '{8'h80, 4'h0, 1'b1, 1'b0, 2'd3, 2'd1, 1'b0, 4'hF, 4'h0};
        vecs[25] = '{8'h00, 4'h0, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 4'hF, 4'h8};
        vecs[26] = '{8'h00, 4'h0, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 4'hF, 4'h0};
        // wrap-around search from core 3
        vecs[27] = '{8'h22, 4'h0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b0, 4'hA, 4'h0};
        vecs[28] = '{8'h20, 4'h0, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 4'hB, 4'h0};
        vecs[29] = '{8'h00, 4'h0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 4'hF, 4'h0};

        // Reset then idle
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_grant", 64'(bus.grant_idx), 64'd0);
        chk("rst_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_hready", 64'(bus.core_hready), 64'hF);
        chk("rst_hresp", 64'(bus.core_hresp), 64'h0);
        chk("rst_htrans", 64'(bus.dmem_htrans), 64'd0);
        reset = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < C_NV; i++) begin
            @(negedge clk);
            cur       = i;
            tb_htrans = vecs[i].htrans;
            tb_lock   = vecs[i].lock;
            tb_hready = vecs[i].rdy;
            tb_hresp  = vecs[i].resp;
            tb_hrdata = 32'h5000_0000 + 32'(i);
            #2;
            ht = vecs[i].htrans;
            exp_rd = {C_N{tb_hrdata}};
            chk("grant_idx", 64'(bus.grant_idx), 64'(vecs[i].g));
            chk("data_idx", 64'(bus.data_idx), 64'(vecs[i].d));
            chk("data_valid", 64'(bus.data_valid), 64'(vecs[i].v));
            chk("core_hready", 64'(bus.core_hready), 64'(vecs[i].hrdy));
            chk("core_hresp", 64'(bus.core_hresp), 64'(vecs[i].hresp));
            chk("dmem_haddr", 64'(bus.dmem_haddr), 64'({vecs[i].g, addr_tbl[vecs[i].g]}));
            chk("dmem_haddr_notag", 64'(bus0.dmem_haddr), 64'({2'b00, addr_tbl[vecs[i].g]}));
            chk("dmem_htrans", 64'(bus.dmem_htrans), 64'(ht[vecs[i].g*2 +: 2]));
            chk("dmem_hmastlock", 64'(bus.dmem_hmastlock), 64'(vecs[i].lock[vecs[i].g]));
            chk("dmem_hwrite", 64'(bus.dmem_hwrite), 64'(vecs[i].g == 2'd2));
            chk("dmem_hwdata", 64'(bus.dmem_hwdata), 64'(wdat_tbl[vecs[i].d]));
            chk("core_hrdata", 64'(bus.core_hrdata == exp_rd), 64'd1);
            chk("notag_hresp", 64'(bus0.core_hresp), 64'(vecs[i].hresp));
        end

        // Reset while core 1 has a transfer in its data phase
        @(negedge clk);
        cur       = 100;
        tb_htrans = 8'h08;
        tb_lock   = '0;
        tb_hready = 1'b1;
        tb_hresp  = 1'b0;
        #2;
        cyc = 0;
        while (!(bus.data_valid === 1'b1 && bus.data_idx === 2'd1) && cyc < 6) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk("inflight_reached", 64'(bus.data_valid === 1'b1 && bus.data_idx === 2'd1), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("inflight_rst_grant", 64'(bus.grant_idx), 64'd0);
        chk("inflight_rst_data", 64'(bus.data_idx), 64'd0);
        chk("inflight_rst_valid", 64'(bus.data_valid), 64'd0);
        chk("inflight_rst_hready", 64'(bus.core_hready), 64'hD);
        chk("inflight_rst_hresp", 64'(bus.core_hresp), 64'h0);
        reset     = 1'b0;
        tb_htrans = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
